// File: rtl/e203_onehot_cnt.sv
// e203_onehot_cnt: outstanding-transaction counter with one-hot state and a registered binary count
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   clr_i      synchronous clear to count 0; also clears err_o and wins over inc/dec
//   inc_i      request issued (+1)
//   inc_rdy_o  inc accepted this cycle: not full, or an accepted dec frees a slot
//   dec_i      response retired (-1)
//   cnt_o      registered binary count 0..DEPTH
//   empty_o    registered count == 0
//   full_o     registered count == DEPTH
//   afull_o    registered count >= AFULL
//   ovf_o      pulse, cycle after an inc was rejected
//   udf_o      pulse, cycle after a dec arrived while empty
//   err_o      sticky, one-hot state was found corrupt
module e203_onehot_cnt #(
   parameter int DEPTH = 8,
   parameter int AFULL = DEPTH - 1,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_i,
   input  logic          inc_i,
   output logic          inc_rdy_o,
   input  logic          dec_i,
   output logic [CW-1:0] cnt_o,
   output logic          empty_o,
   output logic          full_o,
   output logic          afull_o,
   output logic          ovf_o,
   output logic          udf_o,
   output logic          err_o
);
   if (DEPTH < 1 || AFULL < 0 || AFULL > DEPTH) begin : g_bad_param
      $error("e203_onehot_cnt: need DEPTH>=1 and 0<=AFULL<=DEPTH");
   end
   logic [DEPTH:0] oh, oh_nxt;
   logic [CW-1:0] cnt_nxt;
   logic oh_ok, inc_acc, dec_acc;
   assign inc_rdy_o = ~full_o | (dec_i & ~empty_o);
   assign inc_acc = inc_i & inc_rdy_o;
   assign dec_acc = dec_i & ~empty_o;
   assign oh_ok = $onehot(oh);
   // A corrupt state collapses to count 0 so the flags stay self-consistent.
   always_comb begin
      oh_nxt = (inc_acc & ~dec_acc) ? oh << 1 : (dec_acc & ~inc_acc) ? oh >> 1 : oh;
      if (clr_i || !oh_ok) oh_nxt = (DEPTH + 1)'(1);
      cnt_nxt = '0;
      for (int k = 0; k <= DEPTH; k++) cnt_nxt = cnt_nxt | (oh_nxt[k] ? CW'(k) : '0);
   end
   // Outputs are derived from the next state so they carry no logic after the flops.
   always_ff @(posedge clk) begin
      if (rst) begin
         oh      <= (DEPTH + 1)'(1);
         cnt_o   <= '0;
         empty_o <= 1'b1;
         full_o  <= 1'b0;
         afull_o <= (AFULL == 0);
         ovf_o   <= 1'b0;
         udf_o   <= 1'b0;
         err_o   <= 1'b0;
      end else begin
         oh      <= oh_nxt;
         cnt_o   <= cnt_nxt;
         empty_o <= oh_nxt[0];
         full_o  <= oh_nxt[DEPTH];
         afull_o <= |oh_nxt[DEPTH:AFULL];
         ovf_o   <= ~clr_i & inc_i & ~inc_rdy_o;
         udf_o   <= ~clr_i & dec_i & empty_o;
         err_o   <= ~clr_i & (err_o | ~oh_ok);
      end
   end
endmodule
